arm_alu_core: RTL and testbench
===============================

# arm_alu_core

Registered 32-bit ARM data-processing ALU for the execute stage. Each cycle it evaluates one of the 16 ARM data-processing opcodes on two 32-bit operands. It registers the result and an updated CPSR image, with N/Z/C/V recomputed and all other CPSR bits passed through from `cpsr_prev`. Decode selects the opcode and decides whether to commit the result and flags.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `alu_out`  out  32  registered result.
- `cpsr_next`  out  32  registered updated CPSR.
- `alu_op1`  in  32  operand 1 (Rn).
- `alu_op2`  in  32  operand 2 (shifter output).
- `alu_op_sel`  in  4  opcode, ARM encoding.
- `cpsr_prev`  in  32  current CPSR; the C input comes from bit 29.

CPSR bit positions: N=31, Z=30, C=29, V=28.

## Operation
Opcodes, with R = combinational result:
- 0000 AND: R = op1 & op2.
- 0001 EOR: R = op1 ^ op2.
- 0010 SUB: R = op1 − op2.
- 0011 RSB: R = op2 − op1.
- 0100 ADD: R = op1 + op2.
- 0101 ADC: R = op1 + op2 + C.
- 0110 SBC: R = op1 − op2 − !C.
- 0111 RSC: R = op2 − op1 − !C.
- 1000 TST: as AND.
- 1001 TEQ: as EOR.
- 1010 CMP: as SUB.
- 1011 CMN: as ADD.
- 1100 ORR: R = op1 | op2.
- 1101 MOV: R = op2.
- 1110 BIC: R = op1 & ~op2.
- 1111 MVN: R = ~op2.

Arithmetic:
- Computed with a 33-bit adder. Subtraction is a + ~b + cin, with cin = 1 for SUB/RSB/CMP and cin = C for SBC/RSC.
- C = bit 32 of the adder output, i.e. carry-out. For subtraction C = NOT borrow.
- V = signed overflow: operand sign bits equal (after the b inversion) and the result sign differs.

Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
- C and V are copied from `cpsr_prev`.
- No shifter carry is handled here.

All ops:
- N = R[31].
- Z = (R == 0).
- CPSR bits 27:0 are copied from `cpsr_prev`.
- Flags are always computed. The S-bit decision belongs to the caller.

## Timing
- Inputs are sampled on each rising `clk` edge. `alu_out`/`cpsr_next` reflect those inputs one cycle later, i.e. latency 1.
- There is no enable and no handshake. A new operation is accepted every cycle.
- When `rst_n` is low: `alu_out` = 0 and `cpsr_next` = 0 immediately, independent of `clk`. Both hold until the first rising edge after `rst_n` is released.
- Reset mid-operation discards the in-flight result.
- Wrap-around is modulo 2^32. 0xFFFFFFFF + 1 gives 0 with Z=1, C=1, V=0.
- Feeding `cpsr_next` back into `cpsr_prev` is legal. ADC/SBC/RSC then use the flags of the previous cycle's result.

## Configuration
Macro `ARM_ALU_CMP_ZERO_EN`:
- Defined: for TST, TEQ, CMP and CMN, `alu_out` is registered as 0. `cpsr_next` is still updated normally.
- Undefined: `alu_out` carries R for these opcodes, as for any other.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-cycle → both outputs are 0 without waiting for a clock edge.
  - Release `rst_n` → outputs stay 0 until the next edge.
- Logic, with op1=0x20, op2=0x60, `cpsr_prev`=0:
  - AND → 0x20.
  - EOR → 0x40.
  - ORR → 0x60.
  - Each with N=Z=C=V=0, one cycle after the inputs are applied.
- Subtract, same operands:
  - SUB → 0xFFFFFFC0, N=1, C=0, V=0.
  - RSB → 0x40, C=1, V=0.
  - ADD → 0x80, C=0.
- Carry chain, op1=0xFFFFFFFF, op2=2:
  - BIC → 0xFFFFFFFD, N=1.
  - ADD → 0x1, C=1, V=0.
  - Feed `cpsr_next` back into `cpsr_prev`, then ADC → 0x2, C=1.
- Overflow and zero:
  - ADD 0x7FFFFFFF+1 → 0x80000000, N=1, V=1.
  - SUB 5−5 → 0, Z=1, C=1.
  - `cpsr_prev`=0x0000001F: bits 27:0 pass through unchanged.
- Compare ops:
  - CMP 3,5 → N=1, C=0.
  - `alu_out` = 0xFFFFFFFE with `ARM_ALU_CMP_ZERO_EN` undefined, and 0 with it defined.

Source files
------------

// File: rtl/arm_alu_core.sv
// Registered 32-bit ARM data-processing ALU: one of 16 opcodes per cycle, result and CPSR image one cycle later.
// Optional macro ARM_ALU_CMP_ZERO_EN: TST/TEQ/CMP/CMN register alu_out as zero while still updating flags.
module arm_alu_core (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] alu_out,
  output logic [31:0] cpsr_next,
  input  logic [31:0] alu_op1,
  input  logic [31:0] alu_op2,
  input  logic [3:0]  alu_op_sel,
  input  logic [31:0] cpsr_prev
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  logic        w_c_in;
  logic        w_is_arith;
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [32:0] w_sum;
  logic [31:0] w_logic;
  logic [31:0] w_result;
  logic        w_flag_n;
  logic        w_flag_z;
  logic        w_flag_c;
  logic        w_flag_v;
  logic [31:0] w_alu_d;
  logic [31:0] w_cpsr_d;
  logic        w_unused_nz;
  logic [31:0] r_alu_out;
  logic [31:0] r_cpsr_next;

  assign w_c_in = cpsr_prev[29];

  // Adder operand steering: subtraction is a + ~b + cin with the operands swapped for the reverse forms
  always_comb begin
    w_is_arith = 1'b1;
    w_add_a    = alu_op1;
    w_add_b    = alu_op2;
    w_add_cin  = 1'b0;
    case (alu_op_sel)
      OP_SUB, OP_CMP: begin
        w_add_b   = ~alu_op2;
        w_add_cin = 1'b1;
      end
      OP_RSB: begin
        w_add_a   = alu_op2;
        w_add_b   = ~alu_op1;
        w_add_cin = 1'b1;
      end
      OP_ADD, OP_CMN: begin
        w_add_cin = 1'b0;
      end
      OP_ADC: begin
        w_add_cin = w_c_in;
      end
      OP_SBC: begin
        w_add_b   = ~alu_op2;
        w_add_cin = w_c_in;
      end
      OP_RSC: begin
        w_add_a   = alu_op2;
        w_add_b   = ~alu_op1;
        w_add_cin = w_c_in;
      end
      default: begin
        w_is_arith = 1'b0;
      end
    endcase
  end

  assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {32'd0, w_add_cin};

  // Logical unit; arithmetic opcodes fall to default and are overridden by the adder path
  always_comb begin
    w_logic = 32'd0;
    case (alu_op_sel)
      OP_AND, OP_TST: w_logic = alu_op1 & alu_op2;
      OP_EOR, OP_TEQ: w_logic = alu_op1 ^ alu_op2;
      OP_ORR:         w_logic = alu_op1 | alu_op2;
      OP_MOV:         w_logic = alu_op2;
      OP_BIC:         w_logic = alu_op1 & ~alu_op2;
      OP_MVN:         w_logic = ~alu_op2;
      default:        w_logic = 32'd0;
    endcase
  end

  // Result and flag selection; logical ops preserve the incoming C and V
  always_comb begin
    if (w_is_arith) begin
      w_result = w_sum[31:0];
      w_flag_c = w_sum[32];
      w_flag_v = (w_add_a[31] == w_add_b[31]) && (w_sum[31] != w_add_a[31]);
    end else begin
      w_result = w_logic;
      w_flag_c = cpsr_prev[29];
      w_flag_v = cpsr_prev[28];
    end
  end

  assign w_flag_n = w_result[31];
  assign w_flag_z = (w_result == 32'd0);
  assign w_cpsr_d = {w_flag_n, w_flag_z, w_flag_c, w_flag_v, cpsr_prev[27:0]};

  // Old N/Z are always recomputed, so those two input bits are intentionally never consumed
  assign w_unused_nz = &{1'b0, cpsr_prev[31:30]};

`ifdef ARM_ALU_CMP_ZERO_EN
  logic w_is_cmp;
  assign w_is_cmp = (alu_op_sel[3:2] == 2'b10);
  assign w_alu_d  = w_is_cmp ? 32'd0 : w_result;
`else
  assign w_alu_d  = w_result;
`endif

  // Output registers; asynchronous reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out   <= 32'd0;
      r_cpsr_next <= 32'd0;
    end else begin
      r_alu_out   <= w_alu_d;
      r_cpsr_next <= w_cpsr_d;
    end
  end

  assign alu_out   = r_alu_out;
  assign cpsr_next = r_cpsr_next;

endmodule

// File: tb/tb_arm_alu_core.sv
// Self-checking bench for arm_alu_core: arithmetic reference model plus hand-computed literal vectors.
module tb_arm_alu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_out;
  logic [31:0] cpsr_next;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_op_sel;
  logic [31:0] cpsr_prev;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_alu  = 32'd0;
  logic [31:0] exp_cpsr = 32'd0;

  arm_alu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_out    (alu_out),
    .cpsr_next  (cpsr_next),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_op_sel (alu_op_sel),
    .cpsr_prev  (cpsr_prev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  // Returns {C, V, R} for x + y + ci using wide integer arithmetic
  function automatic logic [33:0] m_add(input logic [31:0] x, input logic [31:0] y, input logic ci);
    longint unsigned ux, uy, u;
    longint sx, sy, s;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    u = ux + uy + ci;
    s = sx + sy + ci;
    return {(u > 64'h0000_0000_FFFF_FFFF), (s > 64'sd2147483647) || (s < -64'sd2147483648), u[31:0]};
  endfunction

  // Returns {C, V, R} for x - y - bw; C is NOT borrow
  function automatic logic [33:0] m_sub(input logic [31:0] x, input logic [31:0] y, input logic bw);
    longint ux, uy, d, sx, sy, s;
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    sx = $signed(x); sy = $signed(y);
    d = ux - uy - bw;
    s = sx - sy - bw;
    return {(d >= 64'sd0), (s > 64'sd2147483647) || (s < -64'sd2147483648), d[31:0]};
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] cp);
    logic [33:0] cvr;
    logic [31:0] r;
    logic [31:0] o;
    cvr = {cp[29], cp[28], 32'd0};
    case (op)
      4'd0, 4'd8:  cvr[31:0] = a & b;
      4'd1, 4'd9:  cvr[31:0] = a ^ b;
      4'd12:       cvr[31:0] = a | b;
      4'd13:       cvr[31:0] = b;
      4'd14:       cvr[31:0] = a & ~b;
      4'd15:       cvr[31:0] = ~b;
      4'd2, 4'd10: cvr = m_sub(a, b, 1'b0);
      4'd3:        cvr = m_sub(b, a, 1'b0);
      4'd4, 4'd11: cvr = m_add(a, b, 1'b0);
      4'd5:        cvr = m_add(a, b, cp[29]);
      4'd6:        cvr = m_sub(a, b, !cp[29]);
      default:     cvr = m_sub(b, a, !cp[29]);
    endcase
    r = cvr[31:0];
    o = r;
`ifdef ARM_ALU_CMP_ZERO_EN
    if (op >= 4'd8 && op <= 4'd11) o = 32'd0;
`endif
    return {o, r[31], (r == 32'd0), cvr[33], cvr[32], cp[27:0]};
  endfunction

  // Reference model: expected registered outputs, cleared asynchronously like the design
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_alu  <= 32'd0;
      exp_cpsr <= 32'd0;
    end else begin
      {exp_alu, exp_cpsr} <= model(alu_op_sel, alu_op1, alu_op2, cpsr_prev);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check32("model_alu_out", alu_out, exp_alu);
      check32("model_cpsr_next", cpsr_next, exp_cpsr);
    end
  end

  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] cp);
    @(negedge clk);
    alu_op_sel = op; alu_op1 = a; alu_op2 = b; cpsr_prev = cp;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] ea, input logic [31:0] ec);
    check32({name, "_alu"}, alu_out, ea);
    check32({name, "_cpsr"}, cpsr_next, ec);
  endtask

  logic [31:0] tbl_a [4] = '{32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
  logic [31:0] tbl_b [4] = '{32'h0F0F_0F0F, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] tbl_c [4] = '{32'h0000_0000, 32'h2000_0000, 32'hF000_000A, 32'h3000_0000};
  logic [31:0] cmp_exp;

  initial begin
    rst_n = 1'b0;
    alu_op_sel = 4'd0; alu_op1 = 32'd0; alu_op2 = 32'd0; cpsr_prev = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    apply(4'b0000, 32'h20, 32'h60, 32'h0); expect_out("and",  32'h20, 32'h0);
    apply(4'b0001, 32'h20, 32'h60, 32'h0); expect_out("eor",  32'h40, 32'h0);
    apply(4'b1100, 32'h20, 32'h60, 32'h0); expect_out("orr",  32'h60, 32'h0);
    apply(4'b0010, 32'h20, 32'h60, 32'h0); expect_out("sub",  32'hFFFF_FFC0, 32'h8000_0000);
    apply(4'b0011, 32'h20, 32'h60, 32'h0); expect_out("rsb",  32'h40, 32'h2000_0000);
    apply(4'b0100, 32'h20, 32'h60, 32'h0); expect_out("add",  32'h80, 32'h0);

    apply(4'b1110, 32'hFFFF_FFFF, 32'h2, 32'h0); expect_out("bic", 32'hFFFF_FFFD, 32'h8000_0000);
    apply(4'b0100, 32'hFFFF_FFFF, 32'h2, 32'h0); expect_out("add_carry", 32'h1, 32'h2000_0000);
    apply(4'b0101, 32'hFFFF_FFFF, 32'h2, cpsr_next); expect_out("adc_fb", 32'h2, 32'h2000_0000);
    apply(4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0); expect_out("wrap", 32'h0, 32'h6000_0000);

    apply(4'b0100, 32'h7FFF_FFFF, 32'h1, 32'h0); expect_out("ovf", 32'h8000_0000, 32'h9000_0000);
    apply(4'b0010, 32'h5, 32'h5, 32'h0); expect_out("sub_zero", 32'h0, 32'h6000_0000);
    apply(4'b0000, 32'h20, 32'h60, 32'h0000_001F); expect_out("pass_low", 32'h20, 32'h0000_001F);
    apply(4'b0000, 32'h20, 32'h60, 32'h3000_001F); expect_out("keep_cv", 32'h20, 32'h3000_001F);
    apply(4'b0110, 32'h10, 32'h3, 32'h0); expect_out("sbc_borrow", 32'hC, 32'h2000_0000);
    apply(4'b0111, 32'h3, 32'h10, 32'h2000_0000); expect_out("rsc_c1", 32'hD, 32'h2000_0000);

`ifdef ARM_ALU_CMP_ZERO_EN
    cmp_exp = 32'h0;
`else
    cmp_exp = 32'hFFFF_FFFE;
`endif
    apply(4'b1010, 32'h3, 32'h5, 32'h0); expect_out("cmp", cmp_exp, 32'h8000_0000);

    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 4; k++) begin
        apply(op[3:0], tbl_a[k], tbl_b[k], tbl_c[k]);
      end
    end

    // Asynchronous reset mid-cycle, then release holding zero until the next edge
    apply(4'b0000, 32'h20, 32'h60, 32'h0000_001F);
    expect_out("pre_reset", 32'h20, 32'h0000_001F);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    expect_out("rst_held", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_out("rst_release", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    expect_out("post_reset", 32'h20, 32'h0000_001F);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
